// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and frame line levels
// (the frame levels are also used by the transmitter).
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_rx_state_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous rx pin plus falling-edge detect
// on the synchronized level.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic rx_sync,
  output logic fall
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic prev_q, prev_d;

  always_comb begin
    s1_d   = rx;
    s2_d   = s1_q;
    prev_d = s2_q;
  end

  // Reset to the idle-high level so leaving reset never looks like a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      prev_q <= prev_d;
    end
  end

  assign rx_sync = s2_q;
  assign fall    = prev_q & ~s2_q;

endmodule

// File: rtl/uart_receiver.sv
// Oversampling UART receiver: 8N1-style framing with DEPTH data bits, a
// one-word holding register on a valid/ready port, framing-error and overrun pulses.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int DEPTH        = 5,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx,
  output logic [DEPTH-1:0] data_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             frame_err,
  output logic             overrun
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DEPTH + 1);

  localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  // Handshake: a word moves on any cycle where data_valid and data_ready are
  // both high; data_out holds steady while data_valid is high until that happens.

  logic rx_sync;
  logic fall;

  uart_rx_sync u_sync (
    .clk     (clk),
    .rst     (rst),
    .rx      (rx),
    .rx_sync (rx_sync),
    .fall    (fall)
  );

  uart_rx_state_t   state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [DEPTH-1:0] shift_q, shift_d;
  logic [DEPTH-1:0] hold_q, hold_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic             ovr_q, ovr_d;
  logic             pop;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    shift_d = shift_q;
    hold_d  = hold_q;
    valid_d = valid_q;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;
    pop     = valid_q & data_ready;

    if (pop) valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (fall) begin
          state_d = START;
          idx_d   = '0;
        end
      end
      START: begin
        // Mid-bit check of the start bit; a high level here was only a glitch.
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = (rx_sync == START_BIT) ? DATA : IDLE;
        end
      end
      DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shift_d = DEPTH'({rx_sync, shift_q} >> 1);
          idx_d   = idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            state_d = STOP;
            idx_d   = '0;
          end
        end
      end
      STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (rx_sync == STOP_BIT) begin
            if (!valid_q || pop) begin
              hold_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              ovr_d = 1'b1;
            end
          end else begin
            ferr_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      hold_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      hold_q  <= hold_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign data_out   = hold_q;
  assign data_valid = valid_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;

endmodule
